// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// memory-wait FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module hazard_sat_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the F/D/E/M/W core: EX forwarding, load-use/RAW stalls,
// branch flushes, a memory-wait FSM and saturating stall/flush counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32,
    parameter int FORWARD_EN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] rs1D_i,
    input  logic [ADDR_WIDTH-1:0] rs2D_i,
    input  logic [ADDR_WIDTH-1:0] rs1E_i,
    input  logic [ADDR_WIDTH-1:0] rs2E_i,
    input  logic [ADDR_WIDTH-1:0] rdE_i,
    input  logic [ADDR_WIDTH-1:0] rdM_i,
    input  logic [ADDR_WIDTH-1:0] rdW_i,
    input  logic                  reg_writeE_i,
    input  logic                  reg_writeM_i,
    input  logic                  reg_writeW_i,
    input  logic                  loadE_i,
    input  logic                  pc_srcE_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            forward_aE_o,
    output logic [1:0]            forward_bE_o,
    output logic                  stallF_o,
    output logic                  stallD_o,
    output logic                  stallE_o,
    output logic                  stallM_o,
    output logic                  flushD_o,
    output logic                  flushE_o,
    output logic                  flushW_o,
    output logic                  mem_wait_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic hit(input logic [ADDR_WIDTH-1:0] rd,
                                 input logic [ADDR_WIDTH-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

    hz_state_t state, state_next;
    fwd_sel_t  fwd_a, fwd_b;
    logic      data_stall;
    logic      mem_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Memory handshake: mem_req_i is held by M for the whole access; the access
    // completes in the cycle mem_ack_i is high, and the pipeline advances on that edge.
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    state_next = MEM_WAIT;
                    mem_stall  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_next = RUN;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        data_stall = 1'b0;
        if (FORWARD_EN != 0) begin
            if (reg_writeM_i && hit(rdM_i, rs1E_i))      fwd_a = FWD_M;
            else if (reg_writeW_i && hit(rdW_i, rs1E_i)) fwd_a = FWD_W;
            if (reg_writeM_i && hit(rdM_i, rs2E_i))      fwd_b = FWD_M;
            else if (reg_writeW_i && hit(rdW_i, rs2E_i)) fwd_b = FWD_W;
            data_stall = loadE_i && (hit(rdE_i, rs1D_i) || hit(rdE_i, rs2D_i));
        end else begin
            data_stall = (reg_writeE_i && (hit(rdE_i, rs1D_i) || hit(rdE_i, rs2D_i)))
                      || (reg_writeM_i && (hit(rdM_i, rs1D_i) || hit(rdM_i, rs2D_i)))
                      || (reg_writeW_i && (hit(rdW_i, rs1D_i) || hit(rdW_i, rs2D_i)));
        end
    end

    // Priority: reset > memory wait > control flush > data stall.
    always_comb begin
        forward_aE_o = 2'b00;
        forward_bE_o = 2'b00;
        stallF_o     = 1'b0;
        stallD_o     = 1'b0;
        stallE_o     = 1'b0;
        stallM_o     = 1'b0;
        flushD_o     = 1'b0;
        flushE_o     = 1'b0;
        flushW_o     = 1'b0;
        mem_wait_o   = 1'b0;
        if (rst_i) begin
            flushD_o = 1'b1;
            flushE_o = 1'b1;
            flushW_o = 1'b1;
        end else begin
            forward_aE_o = fwd_a;
            forward_bE_o = fwd_b;
            mem_wait_o   = (state == MEM_WAIT);
            if (mem_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
                flushW_o = 1'b1;
            end else if (pc_srcE_i) begin
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (data_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end
    end

    hazard_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .inc (stallF_o),
        .cnt (stall_cnt_o)
    );

    hazard_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .inc (flushD_o && !rst_i),
        .cnt (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a forwarding instance and a no-forwarding instance with
// narrow counters share stimulus; a scoreboard checks the combinational outputs each cycle.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       reg_writeE, reg_writeM, reg_writeW, loadE, pc_srcE, mem_req, mem_ack;
    logic       sel_b;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic        sF_a, sD_a, sE_a, sM_a, fD_a, fE_a, fW_a, mw_a;
    logic        sF_b, sD_b, sE_b, sM_b, fD_b, fE_b, fW_b, mw_b;
    logic [31:0] stall_cnt_a, flush_cnt_a;
    logic [3:0]  stall_cnt_b, flush_cnt_b;

    int errors = 0;
    int checks = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    // Output vector: {fa[1:0], fb[1:0], stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_wait}
    localparam logic [11:0] V_IDLE   = 12'h000;
    localparam logic [11:0] V_RST    = 12'h00E;
    localparam logic [11:0] V_DSTALL = 12'h0C4;
    localparam logic [11:0] V_FLUSH  = 12'h00C;
    localparam logic [11:0] V_MEM    = 12'h0F2;
    localparam logic [11:0] V_MEMW   = 12'h0F3;
    localparam logic [11:0] V_ACKW   = 12'h001;

    hazard_unit #(.ADDR_WIDTH(5), .CNT_WIDTH(32), .FORWARD_EN(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .reg_writeE_i(reg_writeE), .reg_writeM_i(reg_writeM), .reg_writeW_i(reg_writeW),
        .loadE_i(loadE), .pc_srcE_i(pc_srcE), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .forward_aE_o(fa_a), .forward_bE_o(fb_a),
        .stallF_o(sF_a), .stallD_o(sD_a), .stallE_o(sE_a), .stallM_o(sM_a),
        .flushD_o(fD_a), .flushE_o(fE_a), .flushW_o(fW_a), .mem_wait_o(mw_a),
        .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
    );

    hazard_unit #(.ADDR_WIDTH(5), .CNT_WIDTH(4), .FORWARD_EN(0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .reg_writeE_i(reg_writeE), .reg_writeM_i(reg_writeM), .reg_writeW_i(reg_writeW),
        .loadE_i(loadE), .pc_srcE_i(pc_srcE), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .forward_aE_o(fa_b), .forward_bE_o(fb_b),
        .stallF_o(sF_b), .stallD_o(sD_b), .stallE_o(sE_b), .stallM_o(sM_b),
        .flushD_o(fD_b), .flushE_o(fE_b), .flushW_o(fW_b), .mem_wait_o(mw_b),
        .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: compare selected instance against the expected queue at negedge
    logic [11:0] obs;
    assign obs = sel_b ? {fa_b, fb_b, sF_b, sD_b, sE_b, sM_b, fD_b, fE_b, fW_b, mw_b}
                       : {fa_a, fb_a, sF_a, sD_a, sE_a, sM_a, fD_a, fE_a, fW_a, mw_a};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [11:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {20'd0, obs}, {20'd0, e});
        end
    end

    // driver tasks
    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        reg_writeE = 1'b0; reg_writeM = 1'b0; reg_writeW = 1'b0;
        loadE = 1'b0; pc_srcE = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [11:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel_b = 1'b0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_outputs", V_RST);
        check("reset_stall_cnt", stall_cnt_a, 32'd0);
        check("reset_flush_cnt", flush_cnt_a, 32'd0);
        rst = 1'b0;

        // forwarding priority and x0
        reg_writeM = 1'b1; rdM = 5'd5; reg_writeW = 1'b1; rdW = 5'd5;
        rs1E = 5'd5; rs2E = 5'd5;
        cyc("fwd_m_priority", 12'h A00);
        reg_writeM = 1'b0;
        cyc("fwd_w", 12'h500);
        reg_writeM = 1'b1; rdM = 5'd0; rdW = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
        cyc("fwd_x0", V_IDLE);
        rdM = 5'd5; rdW = 5'd6; rs1E = 5'd5; rs2E = 5'd6;
        cyc("fwd_mixed", 12'h900);
        clear_inputs();

        // load-use stall
        loadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
        cyc("load_use", V_DSTALL);
        check("load_use_stall_cnt", stall_cnt_a, 32'd1);
        rdE = 5'd0;
        cyc("load_use_other_rd", V_IDLE);
        rs2D = 5'd0;
        cyc("load_use_x0", V_IDLE);
        check("no_stall_cnt", stall_cnt_a, 32'd1);

        // control flush beats data stall
        rdE = 5'd7; rs2D = 5'd7; pc_srcE = 1'b1;
        cyc("flush_over_stall", V_FLUSH);
        check("flush_cnt_1", flush_cnt_a, 32'd1);
        check("flush_no_stall_cnt", stall_cnt_a, 32'd1);
        loadE = 1'b0;
        cyc("flush_only", V_FLUSH);
        check("flush_cnt_2", flush_cnt_a, 32'd2);
        clear_inputs();

        // memory wait: request cycle + 3 wait cycles, then ack
        mem_req = 1'b1;
        cyc("mem_req_cycle", V_MEM);
        cyc("mem_wait_1", V_MEMW);
        pc_srcE = 1'b1;
        cyc("mem_wait_pc_src", V_MEMW);
        pc_srcE = 1'b0; loadE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
        cyc("mem_wait_load_use", V_MEMW);
        loadE = 1'b0; rdE = 5'd0; rs1D = 5'd0; mem_ack = 1'b1;
        cyc("mem_ack_cycle", V_ACKW);
        check("mem_stall_cnt", stall_cnt_a, 32'd5);
        check("mem_flush_cnt", flush_cnt_a, 32'd2);
        mem_req = 1'b0; mem_ack = 1'b0;
        cyc("mem_back_to_run", V_IDLE);
        mem_req = 1'b1; mem_ack = 1'b1;
        cyc("mem_zero_wait", V_IDLE);
        check("zero_wait_stall_cnt", stall_cnt_a, 32'd5);

        // reset during MEM_WAIT
        mem_ack = 1'b0;
        cyc("mem_req_again", V_MEM);
        rst = 1'b1;
        cyc("reset_in_wait", V_RST);
        check("reset_wait_stall_cnt", stall_cnt_a, 32'd0);
        check("reset_wait_flush_cnt", flush_cnt_a, 32'd0);
        cyc("reset_held", V_RST);
        rst = 1'b0; mem_req = 1'b0;
        cyc("after_reset_run", V_IDLE);
        clear_inputs();

        // no-forwarding instance: RAW stalls on E/M/W
        sel_b = 1'b1;
        reg_writeW = 1'b1; rdW = 5'd3; rs1D = 5'd3; rs1E = 5'd3; rs2E = 5'd3;
        reg_writeM = 1'b1; rdM = 5'd3;
        cyc("raw_w_no_fwd", V_DSTALL);
        reg_writeM = 1'b0; rdM = 5'd0; reg_writeW = 1'b0; rdW = 5'd0; rs1D = 5'd0;
        reg_writeE = 1'b1; rdE = 5'd4; rs2D = 5'd4;
        cyc("raw_e", V_DSTALL);
        reg_writeE = 1'b0; rdE = 5'd0; rs2D = 5'd0;
        reg_writeM = 1'b1; rdM = 5'd9; rs1D = 5'd9;
        cyc("raw_m", V_DSTALL);
        reg_writeM = 1'b0;
        cyc("raw_disabled_rd", V_IDLE);
        clear_inputs();
        mem_req = 1'b1; mem_ack = 1'b1;
        cyc("b_zero_wait", V_IDLE);
        check("b_stall_cnt", {28'd0, stall_cnt_b}, 32'd3);
        clear_inputs();

        // saturation of the 4-bit stall counter
        reg_writeW = 1'b1; rdW = 5'd3; rs1D = 5'd3;
        for (int i = 1; i <= 16; i++) begin
            cyc("raw_sat", V_DSTALL);
            check("stall_cnt_sat", {28'd0, stall_cnt_b}, (3 + i > 15) ? 32'd15 : 32'(3 + i));
        end
        check("b_flush_cnt", {28'd0, flush_cnt_b}, 32'd0);
        clear_inputs();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
